data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 110 +++++++++++
 tb/tb_data_mem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Bus between the EX/MEM stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Ready;
  logic        Stall;
  logic        AddrErr;
  logic [7:0]  ErrCount;

  modport master (
    output MemRead, MemWrite, Addr, WData,
    input  RData, Ready, Stall, AddrErr, ErrCount
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WData,
    output RData, Ready, Stall, AddrErr, ErrCount
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word data memory with IDLE/BUSY/DONE handshake, pipeline
// stall generation and a saturating count of rejected requests.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  data_mem_responder_if.slave  mem_io
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             op_wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             ready_q;
  logic [7:0]       errcnt_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic req_any, req_ok, accept, reject, access;

  // Request qualification: only IDLE looks at the inputs, and nothing is
  // flagged while reset is held.
  always_comb begin
    req_any = mem_io.MemRead | mem_io.MemWrite;
    req_ok  = (mem_io.MemRead ^ mem_io.MemWrite) &&
              (mem_io.Addr[1:0] == 2'b00) &&
              (mem_io.Addr[31:2] < 30'(DEPTH_WORDS));
    accept  = (state_q == IDLE) && req_ok && !Rst;
    reject  = (state_q == IDLE) && req_any && !req_ok && !Rst;
    access  = (state_q == BUSY) && (cnt_q == 4'd0);
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, completion pulse and error counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= access;
      if (reject) errcnt_q <= sat_inc8(errcnt_q);
    end
  end

  // Capture of the accepted request; later input changes are ignored.
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_wr_q <= mem_io.MemWrite;
      idx_q   <= mem_io.Addr[IDX_W+1:2];
      wdata_q <= mem_io.WData;
    end
  end

  // Storage array and read register; the access happens only on BUSY->DONE,
  // so a reset during BUSY drops a pending write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rdata_q <= 32'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (access) begin
      if (op_wr_q) mem_q[idx_q] <= wdata_q;
      else         rdata_q      <= mem_q[idx_q];
    end
  end

  assign mem_io.RData    = rdata_q;
  assign mem_io.Ready    = ready_q;
  assign mem_io.Stall    = accept || ((state_q == BUSY) && !Rst);
  assign mem_io.AddrErr  = reject;
  assign mem_io.ErrCount = errcnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed and random requests.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .mem_io(bus)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          issue;
  } cmp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  cmp_t        exp_q[$];
  int          err_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  int          model_err;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    model_rdata = 32'd0;
    model_err   = 0;
    exp_q.delete();
    err_q.delete();
  endtask

  // Monitor: pops expectations whenever the DUT signals completion or rejection.
  initial begin
    int  stall_run;
    bit  err_pend;
    int  err_val;
    cmp_t e;
    stall_run = 0;
    err_pend  = 0;
    err_val   = 0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        stall_run = 0;
        err_pend  = 0;
      end else begin
        if (err_pend) begin
          chk("errcount", {24'd0, bus.ErrCount}, err_val);
          err_pend = 0;
        end
        if (bus.Stall) stall_run++;
        if (bus.AddrErr) begin
          chk("addrerr_expected", (err_q.size() > 0), 1);
          chk("addrerr_nostall", bus.Stall, 0);
          if (err_q.size() > 0) begin
            err_val  = err_q.pop_front();
            err_pend = 1;
          end
        end
        if (bus.Ready) begin
          chk("ready_expected", (exp_q.size() > 0), 1);
          chk("ready_nostall", bus.Stall, 0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.is_rd ? "rdata_read" : "rdata_after_write", bus.RData, e.data);
            chk("ready_latency", cyc - e.issue, LAT + 1);
            chk("stall_cycles", stall_run, LAT + 1);
          end
          stall_run = 0;
        end
      end
    end
  end

  // Present one request in a fresh cycle; valid ones are held until Stall drops.
  task automatic present(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit wiggle);
    bit   ok, done;
    int   idx;
    cmp_t e;
    @(posedge Clk); #1;
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.Addr     = addr;
    bus.WData    = wd;
    ok = (rd ^ wr) && (addr[1:0] == 2'b00) && (addr[31:2] < DEPTH);
    if (ok) begin
      idx = int'(addr[31:2]);
      if (wr) model_mem[idx] = wd;
      else    model_rdata    = model_mem[idx];
      e.is_rd = rd;
      e.data  = model_rdata;
      e.issue = cyc;
      exp_q.push_back(e);
      done = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge Clk);
        if (!bus.Stall) begin
          done = 1;
          break;
        end
        @(posedge Clk); #1;
        if (wiggle) begin
          bus.MemRead  = ~rd;
          bus.Addr     = addr ^ 32'h4;
          bus.WData    = ~wd;
        end
      end
      chk("handshake_timeout", done, 1);
    end else begin
      if (rd | wr) begin
        if (model_err < 255) model_err++;
        err_q.push_back(model_err);
      end
      @(negedge Clk);
      chk("reject_or_idle_nostall", bus.Stall, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Addr     = 32'd0;
    bus.WData    = 32'd0;
    model_reset();

    // Reset state, with a request visible while reset is held.
    #1;
    bus.MemRead = 1'b1;
    bus.Addr    = 32'h13;
    #1;
    chk("rst_addrerr", bus.AddrErr, 0);
    chk("rst_stall", bus.Stall, 0);
    chk("rst_ready", bus.Ready, 0);
    chk("rst_rdata", bus.RData, 0);
    chk("rst_errcount", {24'd0, bus.ErrCount}, 0);
    bus.Addr = 32'h10;
    #1;
    chk("rst_stall_valid_req", bus.Stall, 0);
    bus.MemRead = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // Write then read of the same word, back to back.
    present(0, 1, 32'h10, 32'hDEADBEEF, 0);
    present(1, 0, 32'h10, 32'h0, 0);

    // Misaligned read rejected, then saturate the error counter.
    for (int i = 0; i < 300; i++) present(1, 0, 32'h13, 32'h0, 0);
    present(0, 0, 32'h0, 32'h0, 0);
    chk("errcount_saturated", {24'd0, bus.ErrCount}, 255);
    present(1, 0, 32'h10, 32'h0, 0);

    // Both strobes, and out-of-range address.
    present(1, 1, 32'h04, 32'h0, 0);
    present(1, 0, 32'h4 * DEPTH, 32'h0, 0);
    present(0, 1, 32'h8000_0000, 32'h55, 0);

    // Inputs changing during BUSY are ignored.
    present(0, 1, 32'h04, 32'h0BADF00D, 0);
    present(1, 0, 32'h00, 32'h0, 1);
    present(1, 0, 32'h04, 32'h0, 1);

    // Reset during a pending write aborts it.
    @(posedge Clk); #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.Addr     = 32'h20;
    bus.WData    = 32'h1234;
    @(posedge Clk); #1;
    chk("busy_stall_before_rst", bus.Stall, 1);
    Rst = 1'b1;
    #1;
    model_reset();
    chk("abort_stall", bus.Stall, 0);
    chk("abort_ready", bus.Ready, 0);
    chk("abort_rdata", bus.RData, 0);
    chk("abort_errcount", {24'd0, bus.ErrCount}, 0);
    chk("abort_addrerr", bus.AddrErr, 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    bus.MemWrite = 1'b0;
    present(1, 0, 32'h20, 32'h0, 0);
    present(1, 0, 32'h10, 32'h0, 0);

    // Randomized traffic over a small address window to provoke reuse.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 10);
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      case (r)
        0, 1, 2, 3: present(1, 0, a, 32'h0, 1'($urandom_range(0, 1)));
        4, 5, 6:    present(0, 1, a, $urandom, 1'($urandom_range(0, 1)));
        7:          present(1, 1, a, $urandom, 0);
        8:          present(1'($urandom_range(0, 1)), 1'b1, a | 32'($urandom_range(1, 3)), 32'h0, 0);
        9:          present(1, 0, (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2, 32'h0, 0);
        default:    present(0, 0, a, 32'h0, 0);
      endcase
    end

    repeat (3) present(0, 0, 32'h0, 32'h0, 0);
    chk("completions_drained", exp_q.size(), 0);
    chk("rejects_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
